// File: rtl/sd_dat_tx.sv
// SD write-data transmitter: pops FIFO words and sends 4-bit wide-bus blocks, then reads the CRC status token and waits out busy.
// Latency: one SD clock of start bit after a full block is buffered; every DAT change is registered on i_sd_clk_stb.
// Backpressure: a block starts only once BLOCK_WORDS words are buffered; no strobes means a full stall with no timeout counting.
//
// Ports: i_clk/i_reset (sync, active-high); i_sd_clk_stb/i_sd_clk_smp SD clock falling/rising strobes;
//        i_start/i_abort/i_blocks control; o_fifo_pop/i_fifo_empty/i_fifo_items/i_fifo_data show-ahead FIFO;
//        o_sd_dat/o_sd_dat_oe/i_sd_dat0 pads; o_busy/o_done/o_crc_error/o_timeout status.
module sd_dat_tx #(
    parameter int BLOCK_WORDS    = 128,
    parameter int STATUS_TIMEOUT = 64,
    parameter int BUSY_TIMEOUT   = 1048576
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_sd_clk_stb,
    input  logic        i_sd_clk_smp,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [7:0]  i_blocks,
    output logic        o_fifo_pop,
    input  logic        i_fifo_empty,
    input  logic [8:0]  i_fifo_items,
    input  logic [31:0] i_fifo_data,
    output logic [3:0]  o_sd_dat,
    output logic        o_sd_dat_oe,
    input  logic        i_sd_dat0,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_crc_error,
    output logic        o_timeout
);

    localparam int NIBS = BLOCK_WORDS * 8;
    localparam int CW   = $clog2(NIBS);
    localparam int TW   = $clog2(BUSY_TIMEOUT + STATUS_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_NIB = CW'(NIBS - 1);
    localparam logic [CW-1:0] LAST_CRC = CW'(15);
    localparam logic [TW-1:0] STS_LAST = TW'(STATUS_TIMEOUT - 1);
    localparam logic [TW-1:0] BSY_LAST = TW'(BUSY_TIMEOUT);
    localparam logic [8:0]    FULL_BLK = 9'(BLOCK_WORDS);

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT, S_START, S_DATA, S_CRC, S_END, S_STATUS, S_BUSY, S_FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;      // nibble / CRC bit / token bit index
    logic [TW-1:0]    tcnt_q, tcnt_d;    // status and busy timeout counter
    logic [27:0]      sreg_q, sreg_d;    // remaining nibbles of the current word
    logic [3:0][15:0] crc_q, crc_d;      // one CRC16 per DAT line
    logic [2:0]       tok_q, tok_d;
    logic             tok_go_q, tok_go_d; // token start bit seen
    logic [7:0]       blk_q, blk_d, last_q, last_d;
    logic [3:0]       dat_d;
    logic             oe_d, crc_err_d, tmo_d;
    logic             emit;
    logic [3:0]       nib;

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic d);
        return {c[14:0], 1'b0} ^ ({16{c[15] ^ d}} & 16'h1021);
    endfunction

    assign o_busy = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign o_done = (state_q == S_FINISH);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tcnt_d     = tcnt_q;
        sreg_d     = sreg_q;
        crc_d      = crc_q;
        tok_d      = tok_q;
        tok_go_d   = tok_go_q;
        blk_d      = blk_q;
        last_d     = last_q;
        dat_d      = o_sd_dat;
        oe_d       = o_sd_dat_oe;
        crc_err_d  = o_crc_error;
        tmo_d      = o_timeout;
        o_fifo_pop = 1'b0;
        emit       = 1'b0;
        nib        = 4'h0;

        case (state_q)
            S_IDLE: if (i_start) begin
                state_d   = S_WAIT;
                crc_err_d = 1'b0;
                tmo_d     = 1'b0;
                last_d    = i_blocks;
                blk_d     = 8'd0;
            end
            S_WAIT: if (i_sd_clk_stb && !i_fifo_empty && i_fifo_items >= FULL_BLK) begin
                state_d = S_START;
                oe_d    = 1'b1;
                dat_d   = 4'h0;
                crc_d   = '0;
            end
            S_START: if (i_sd_clk_stb) begin
                state_d    = S_DATA;
                cnt_d      = '0;
                o_fifo_pop = 1'b1;
                emit       = 1'b1;
                nib        = i_fifo_data[31:28];
                sreg_d     = i_fifo_data[27:0];
            end
            S_DATA: if (i_sd_clk_stb) begin
                if (cnt_q == LAST_NIB) begin
                    state_d = S_CRC;
                    cnt_d   = '0;
                    for (int i = 0; i < 4; i++) begin
                        dat_d[i] = crc_q[i][15];
                        crc_d[i] = {crc_q[i][14:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    emit  = 1'b1;
                    // Next nibble starts a new word: pop and load in the same strobe.
                    if (cnt_q[2:0] == 3'd7) begin
                        o_fifo_pop = 1'b1;
                        nib        = i_fifo_data[31:28];
                        sreg_d     = i_fifo_data[27:0];
                    end else begin
                        nib    = sreg_q[27:24];
                        sreg_d = {sreg_q[23:0], 4'h0};
                    end
                end
            end
            S_CRC: if (i_sd_clk_stb) begin
                if (cnt_q == LAST_CRC) begin
                    state_d = S_END;
                    dat_d   = 4'hF;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        dat_d[i] = crc_q[i][15];
                        crc_d[i] = {crc_q[i][14:0], 1'b0};
                    end
                end
            end
            S_END: if (i_sd_clk_stb) begin
                state_d  = S_STATUS;
                oe_d     = 1'b0;
                dat_d    = 4'hF;
                cnt_d    = '0;
                tcnt_d   = '0;
                tok_go_d = 1'b0;
            end
            S_STATUS: if (i_sd_clk_smp) begin
                if (!tok_go_q) begin
                    if (!i_sd_dat0) begin
                        tok_go_d = 1'b1;
                        cnt_d    = '0;
                    end else if (tcnt_q == STS_LAST) begin
                        tmo_d   = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end else begin
                    tok_d = {tok_q[1:0], i_sd_dat0};
                    if (cnt_q == CW'(2)) begin
                        if ({tok_q[1:0], i_sd_dat0} != 3'b010) crc_err_d = 1'b1;
                        state_d = S_BUSY;
                        tcnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_BUSY: if (i_sd_clk_smp) begin
                if (i_sd_dat0) begin
                    // A bad token ends the transfer once the card releases busy.
                    if (o_crc_error || blk_q == last_q) begin
                        state_d = S_FINISH;
                    end else begin
                        blk_d   = blk_q + 8'd1;
                        state_d = S_WAIT;
                    end
                end else if (tcnt_q == BSY_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (emit) begin
            dat_d = nib;
            for (int i = 0; i < 4; i++) crc_d[i] = crc16_step(crc_q[i], nib[i]);
        end

        // Abort keeps the error flags and must not pop.
        if (i_abort || i_reset) begin
            state_d    = S_IDLE;
            oe_d       = 1'b0;
            dat_d      = 4'hF;
            o_fifo_pop = 1'b0;
            crc_err_d  = o_crc_error;
            tmo_d      = o_timeout;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tcnt_q      <= '0;
            sreg_q      <= '0;
            crc_q       <= '0;
            tok_q       <= '0;
            tok_go_q    <= 1'b0;
            blk_q       <= '0;
            last_q      <= '0;
            o_sd_dat    <= 4'hF;
            o_sd_dat_oe <= 1'b0;
            o_crc_error <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            sreg_q      <= sreg_d;
            crc_q       <= crc_d;
            tok_q       <= tok_d;
            tok_go_q    <= tok_go_d;
            blk_q       <= blk_d;
            last_q      <= last_d;
            o_sd_dat    <= dat_d;
            o_sd_dat_oe <= oe_d;
            o_crc_error <= crc_err_d;
            o_timeout   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_sd_dat_tx.sv
module tb_sd_dat_tx;

    localparam int BW   = 128;
    localparam int BT   = 200;
    localparam int NIBS = BW * 8;

    logic        i_clk = 1'b0;
    logic        i_reset, stb, smp, start, abort;
    logic [7:0]  blocks;
    logic        pop, empty;
    logic [8:0]  items;
    logic [31:0] fdata;
    logic [3:0]  dat;
    logic        oe, dat0, busy, done, crc_err, tmo;

    always #5 i_clk = ~i_clk;

    sd_dat_tx #(.BLOCK_WORDS(BW), .STATUS_TIMEOUT(64), .BUSY_TIMEOUT(BT)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_sd_clk_stb(stb), .i_sd_clk_smp(smp),
        .i_start(start), .i_abort(abort), .i_blocks(blocks),
        .o_fifo_pop(pop), .i_fifo_empty(empty), .i_fifo_items(items), .i_fifo_data(fdata),
        .o_sd_dat(dat), .o_sd_dat_oe(oe), .i_sd_dat0(dat0),
        .o_busy(busy), .o_done(done), .o_crc_error(crc_err), .o_timeout(tmo)
    );

    int          n_chk = 0, n_fail = 0;
    int          pop_cnt = 0, done_cnt = 0, hold_viol = 0;
    int          pc0, dc0, pc1;
    logic [31:0] fifo_q[$];
    logic [31:0] sent_q[$];
    logic [3:0]  stream[$];
    logic [3:0]  exp_q[$];
    logic [4:0]  prev_out = 5'h0F;
    logic        oe_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fifo_refresh();
        items = 9'(fifo_q.size());
        empty = (fifo_q.size() == 0);
        fdata = empty ? 32'h0 : fifo_q[0];
    endtask

    task automatic push(input logic [31:0] w);
        fifo_q.push_back(w);
        sent_q.push_back(w);
        fifo_refresh();
    endtask

    task automatic flush();
        fifo_q.delete();
        sent_q.delete();
        fifo_refresh();
    endtask

    // One i_clk cycle: inputs were set at the preceding negedge; outputs read at the next one.
    task automatic tick();
        logic p, s, a, r;
        logic [31:0] junk;
        #1;
        p = pop; s = stb; a = abort; r = i_reset;
        @(negedge i_clk);
        if (p) begin
            pop_cnt++;
            if (fifo_q.size() > 0) junk = fifo_q.pop_front();
        end
        fifo_refresh();
        if (s && oe) stream.push_back(dat);
        if (oe) oe_seen = 1'b1;
        if (done) done_cnt++;
        if (!s && !a && !r && ({oe, dat} !== prev_out)) hold_viol++;
        prev_out = {oe, dat};
    endtask

    task automatic sd_tick();
        stb = 1'b1; tick(); stb = 1'b0;
        smp = 1'b1; tick(); smp = 1'b0;
    endtask

    task automatic start_xfer(input logic [7:0] nblk);
        blocks = nblk; start = 1'b1; tick(); start = 1'b0;
    endtask

    // Runs SD clocks until the block has been sent and oe has dropped again.
    task automatic send_block(input string tag);
        logic seen, ended;
        seen = 1'b0; ended = 1'b0; dat0 = 1'b1;
        stream.delete();
        for (int n = 0; n < 3000 && !ended; n++) begin
            sd_tick();
            if (oe) seen = 1'b1;
            else if (seen) ended = 1'b1;
        end
        chk({tag, "_end_reached"}, ended, 1);
    endtask

    // Card side: token start, three token bits, busy low, then release.
    task automatic reply(input logic [2:0] token, input int busy_len);
        dat0 = 1'b0; sd_tick();
        for (int b = 2; b >= 0; b--) begin dat0 = token[b]; sd_tick(); end
        dat0 = 1'b0;
        for (int n = 0; n < busy_len; n++) sd_tick();
        dat0 = 1'b1; sd_tick();
    endtask

    // Reference block: start nibble, data nibbles MSB nibble first, per-line CRC16
    // as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1, end nibble.
    task automatic build_expected();
        logic [31:0] w[BW];
        bit          m[4][NIBS+16];
        bit [16:0]   g;
        logic [3:0]  n;
        g = 17'h11021;
        for (int i = 0; i < BW; i++) w[i] = sent_q.pop_front();
        exp_q.delete();
        exp_q.push_back(4'h0);
        for (int i = 0; i < BW; i++)
            for (int k = 0; k < 8; k++) begin
                n = w[i][31-4*k -: 4];
                exp_q.push_back(n);
                for (int l = 0; l < 4; l++) m[l][i*8+k] = n[l];
            end
        for (int l = 0; l < 4; l++) begin
            for (int z = 0; z < 16; z++) m[l][NIBS+z] = 1'b0;
            for (int i = 0; i < NIBS; i++)
                if (m[l][i]) for (int j = 0; j <= 16; j++) m[l][i+j] ^= g[16-j];
        end
        for (int c = 0; c < 16; c++)
            exp_q.push_back({m[3][NIBS+c], m[2][NIBS+c], m[1][NIBS+c], m[0][NIBS+c]});
        exp_q.push_back(4'hF);
    endtask

    task automatic check_stream(input string tag);
        int mism;
        build_expected();
        chk({tag, "_len"}, stream.size(), exp_q.size());
        mism = 0;
        for (int i = 0; i < exp_q.size() && i < stream.size(); i++)
            if (stream[i] !== exp_q[i]) mism++;
        chk({tag, "_nibble_mismatches"}, mism, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1; stb = 1'b0; smp = 1'b0; start = 1'b0; abort = 1'b0;
        blocks = 8'd0; dat0 = 1'b1;
        fifo_refresh();
        repeat (3) tick();
        i_reset = 1'b0;
        tick();
        chk("reset_dat", dat, 4'hF);
        chk("reset_oe", oe, 0);
        chk("reset_pop", pop, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_crc_err", crc_err, 0);
        chk("reset_timeout", tmo, 0);

        // One all-zero block, good token, short busy.
        for (int i = 0; i < BW; i++) push(32'h0);
        pc0 = pop_cnt; dc0 = done_cnt;
        start_xfer(8'd0);
        chk("t1_busy_after_start", busy, 1);
        send_block("t1");
        check_stream("t1");
        reply(3'b010, 5);
        tick(); tick();
        chk("t1_pops", pop_cnt - pc0, BW);
        chk("t1_done_pulses", done_cnt - dc0, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_crc_err", crc_err, 0);

        // Known first word plus random data.
        push(32'h12345678);
        for (int i = 1; i < BW; i++) push($urandom);
        dc0 = done_cnt;
        start_xfer(8'd0);
        send_block("t2");
        for (int k = 0; k < 8; k++)
            chk($sformatf("t2_first_nibble_%0d", k), (stream.size() > k + 1) ? stream[k+1] : 4'hx, 32'(k + 1));
        check_stream("t2");
        reply(3'b010, 3);
        tick(); tick();
        chk("t2_done_pulses", done_cnt - dc0, 1);

        // Three blocks with an under-filled FIFO before the second.
        for (int i = 0; i < BW; i++) push($urandom);
        pc0 = pop_cnt; dc0 = done_cnt;
        start_xfer(8'd2);
        send_block("t3_b0");
        check_stream("t3_b0");
        reply(3'b010, 2);
        for (int i = 0; i < BW - 1; i++) push($urandom);
        oe_seen = 1'b0;
        repeat (30) sd_tick();
        chk("t3_hold_oe", oe_seen, 0);
        chk("t3_hold_busy", busy, 1);
        push($urandom);
        send_block("t3_b1");
        check_stream("t3_b1");
        reply(3'b010, 2);
        for (int i = 0; i < BW; i++) push($urandom);
        send_block("t3_b2");
        check_stream("t3_b2");
        reply(3'b010, 2);
        tick(); tick();
        chk("t3_pops", pop_cnt - pc0, 3 * BW);
        chk("t3_done_pulses", done_cnt - dc0, 1);
        chk("t3_busy_end", busy, 0);

        // Bad token on the first of three blocks ends the transfer.
        for (int i = 0; i < 2 * BW; i++) push($urandom);
        pc0 = pop_cnt; dc0 = done_cnt;
        start_xfer(8'd2);
        send_block("t4");
        check_stream("t4");
        reply(3'b101, 4);
        repeat (20) sd_tick();
        chk("t4_crc_err", crc_err, 1);
        chk("t4_pops", pop_cnt - pc0, BW);
        chk("t4_done_pulses", done_cnt - dc0, 1);
        chk("t4_busy_end", busy, 0);
        flush();
        start_xfer(8'd0);
        chk("t4_crc_err_cleared", crc_err, 0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t4_abort_idle", busy, 0);

        // No status start bit: timeout on the 64th sample.
        for (int i = 0; i < BW; i++) push($urandom);
        dc0 = done_cnt;
        start_xfer(8'd0);
        send_block("t5");
        check_stream("t5");
        dat0 = 1'b1;
        repeat (62) sd_tick();
        chk("t5_timeout_early", tmo, 0);
        chk("t5_busy_early", busy, 1);
        sd_tick(); tick();
        chk("t5_timeout", tmo, 1);
        chk("t5_done_pulses", done_cnt - dc0, 1);

        // Busy never released: timeout once BT low samples are exceeded.
        for (int i = 0; i < BW; i++) push($urandom);
        dc0 = done_cnt;
        start_xfer(8'd0);
        chk("t6_timeout_cleared", tmo, 0);
        send_block("t6");
        check_stream("t6");
        dat0 = 1'b0; sd_tick();
        dat0 = 1'b0; sd_tick();
        dat0 = 1'b1; sd_tick();
        dat0 = 1'b0; sd_tick();
        repeat (BT) sd_tick();
        chk("t6_timeout_early", tmo, 0);
        chk("t6_busy_early", busy, 1);
        sd_tick(); tick();
        chk("t6_timeout", tmo, 1);
        chk("t6_crc_err", crc_err, 0);
        chk("t6_done_pulses", done_cnt - dc0, 1);
        dat0 = 1'b1;

        // Abort in the middle of word 40, then a clean transfer.
        for (int i = 0; i < BW; i++) push($urandom);
        pc0 = pop_cnt; dc0 = done_cnt;
        start_xfer(8'd0);
        for (int n = 0; n < 2000 && (pop_cnt - pc0) < 41; n++) sd_tick();
        chk("t7_reached_word40", pop_cnt - pc0, 41);
        sd_tick(); sd_tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t7_abort_oe", oe, 0);
        chk("t7_abort_dat", dat, 4'hF);
        chk("t7_abort_busy", busy, 0);
        pc1 = pop_cnt;
        repeat (30) sd_tick();
        chk("t7_no_pops_after_abort", pop_cnt - pc1, 0);
        chk("t7_no_done", done_cnt - dc0, 0);
        flush();
        for (int i = 0; i < BW; i++) push($urandom);
        pc0 = pop_cnt;
        start_xfer(8'd0);
        send_block("t7_rerun");
        check_stream("t7_rerun");
        reply(3'b010, 2);
        tick(); tick();
        chk("t7_rerun_pops", pop_cnt - pc0, BW);
        chk("t7_rerun_done", done_cnt - dc0, 1);
        chk("t7_rerun_timeout", tmo, 0);

        chk("hold_between_strobes", hold_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
